multi_clock_divider: RTL and testbench

//  NUM_CH independent programmable clock dividers/strobe generators on one clock,

---
 rtl/multi_clock_divider.sv | 59 +++++
 tb/tb_multi_clock_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers / strobe generators sharing one clock.
// Each channel counts to a shadowed divisor and emits a toggle (50% duty) or a 1-cycle pulse.
module multi_clock_divider #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 30
) (
  input  logic                          input_clk,
  input  logic                          input_rst,
  input  logic [NUM_CH-1:0]             input_en,
  input  logic [NUM_CH-1:0]             input_mode,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   input_div,
  input  logic                          input_sync,
  output logic [NUM_CH-1:0]             output_clk,
  output logic [NUM_CH-1:0]             output_tick
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_act;
    logic                 r_out;
    logic                 r_tick;
    logic [DIV_WIDTH-1:0] w_div;
    logic                 w_run;
    logic                 w_event;

    assign w_div   = input_div[g*DIV_WIDTH +: DIV_WIDTH];
    assign w_run   = input_en[g] && (r_div_act != '0);
    assign w_event = (r_cnt == (r_div_act - DIV_WIDTH'(1)));

    // Divisor is only re-sampled while idle or at a period boundary, so a
    // mid-period divisor change never produces a short or stretched period.
    always_ff @(posedge input_clk) begin
      if (input_rst) begin
        r_cnt     <= '0;
        r_div_act <= '0;
        r_out     <= 1'b0;
        r_tick    <= 1'b0;
      end else if (input_sync || !w_run) begin
        r_cnt     <= '0;
        r_div_act <= w_div;
        r_out     <= 1'b0;
        r_tick    <= 1'b0;
      end else if (w_event) begin
        r_cnt     <= '0;
        r_div_act <= w_div;
        r_tick    <= 1'b1;
        r_out     <= input_mode[g] ? 1'b1 : ~r_out;
      end else begin
        r_cnt     <= r_cnt + DIV_WIDTH'(1);
        r_tick    <= 1'b0;
        r_out     <= input_mode[g] ? 1'b0 : r_out;
      end
    end

    assign output_clk[g]  = r_out;
    assign output_tick[g] = r_tick;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: reset, toggle, pulse, D=1, divisor
// update, zero divisor, sync realignment, reset mid-run and enable drop.
module tb_multi_clock_divider;

  localparam int NUM_CH    = 4;
  localparam int DIV_WIDTH = 30;

  logic                        input_clk;
  logic                        input_rst;
  logic [NUM_CH-1:0]           input_en;
  logic [NUM_CH-1:0]           input_mode;
  logic [NUM_CH*DIV_WIDTH-1:0] input_div;
  logic                        input_sync;
  logic [NUM_CH-1:0]           output_clk;
  logic [NUM_CH-1:0]           output_tick;

  int checks   = 0;
  int failures = 0;

  multi_clock_divider #(.NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH)) dut (
    .input_clk   (input_clk),
    .input_rst   (input_rst),
    .input_en    (input_en),
    .input_mode  (input_mode),
    .input_div   (input_div),
    .input_sync  (input_sync),
    .output_clk  (output_clk),
    .output_tick (output_tick)
  );

  // clock / reset
  initial input_clk = 1'b0;
  always #5 input_clk = ~input_clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge input_clk);
    #1;
  endtask

  task automatic set_div(input int ch, input logic [DIV_WIDTH-1:0] val);
    input_div[ch*DIV_WIDTH +: DIV_WIDTH] = val;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    input_rst  = 1'b1;
    input_sync = 1'b0;
    input_en   = '0;
    input_mode = '0;
    input_div  = '0;

    // 1: reset wins over random inputs
    for (int i = 0; i < 3; i++) begin
      input_en   = NUM_CH'($urandom_range(0, 15));
      input_mode = NUM_CH'($urandom_range(0, 15));
      for (int c = 0; c < NUM_CH; c++) set_div(c, DIV_WIDTH'($urandom_range(0, 7)));
      input_sync = 1'($urandom_range(0, 1));
      step();
      check("reset_clk", 32'(output_clk), 32'h0);
      check("reset_tick", 32'(output_tick), 32'h0);
    end

    // 2: ch0 toggle, D=3 (divisor preloaded while idle)
    input_rst  = 1'b0;
    input_sync = 1'b0;
    input_en   = '0;
    input_mode = '0;
    input_div  = '0;
    set_div(0, 3);
    step();
    input_en = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      step();
      check("tog_tick", 32'(output_tick), 32'((i % 3) == 2));
      check("tog_clk", 32'(output_clk), 32'((((i + 1) / 3) % 2) == 1));
    end

    // 3: ch1 pulse, D=5, then D=1 taking effect at the next period boundary
    input_en = '0;
    input_mode = 4'b0010;
    input_div  = '0;
    set_div(1, 5);
    step();
    input_en = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      check("pulse_clk", 32'(output_clk), 32'(((i % 5) == 4) ? 2 : 0));
      check("pulse_tick", 32'(output_tick), 32'(((i % 5) == 4) ? 2 : 0));
    end
    set_div(1, 1);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("d1_pulse_clk", 32'(output_clk), 32'h2);
      check("d1_pulse_tick", 32'(output_tick), 32'h2);
    end

    // 4: ch2 toggle D=4, changed to 2 mid-period, then 0
    input_en   = '0;
    input_mode = '0;
    input_div  = '0;
    set_div(2, 4);
    step();
    input_en = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      step();
      check("upd_tick", 32'(output_tick[2]), 32'(i == 3 || i == 7 || i == 9 || i == 11));
      check("upd_clk", 32'(output_clk[2]), 32'((i >= 3 && i <= 6) || i == 9 || i == 10));
      if (i == 4) set_div(2, 2);
    end
    set_div(2, 0);
    step();
    step();
    check("div0_last_tick", 32'(output_tick[2]), 32'h1);
    step();
    for (int i = 0; i < 5; i++) begin
      check("div0_clk", 32'(output_clk[2]), 32'h0);
      check("div0_tick", 32'(output_tick[2]), 32'h0);
      step();
    end

    // 5: sync realigns ch0 (D=3) and ch1 (D=6)
    input_en   = '0;
    input_mode = '0;
    input_div  = '0;
    set_div(0, 3);
    set_div(1, 6);
    step();
    input_en = 4'b0001;
    step();
    step();
    input_en = 4'b0011;
    for (int i = 0; i < 7; i++) step();
    input_sync = 1'b1;
    step();
    check("sync_clk", 32'(output_clk), 32'h0);
    check("sync_tick", 32'(output_tick), 32'h0);
    input_sync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("sync_tick0", 32'(output_tick[0]), 32'(i == 2 || i == 5));
      check("sync_tick1", 32'(output_tick[1]), 32'(i == 5));
      check("sync_clk0", 32'(output_clk[0]), 32'(i >= 2 && i <= 4));
      check("sync_clk1", 32'(output_clk[1]), 32'(i == 5));
    end

    // 6: reset mid-run clears div_act, so one idle-load edge precedes counting
    input_rst = 1'b1;
    step();
    check("midrst_clk", 32'(output_clk), 32'h0);
    check("midrst_tick", 32'(output_tick), 32'h0);
    input_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rst_tick0", 32'(output_tick[0]), 32'(i == 3 || i == 6));
      check("rst_clk0", 32'(output_clk[0]), 32'(i >= 3 && i <= 5));
      check("rst_tick1", 32'(output_tick[1]), 32'(i == 6));
      check("rst_clk1", 32'(output_clk[1]), 32'(i >= 6));
    end
    input_en[1] = 1'b0;
    step();
    check("endrop_clk1", 32'(output_clk[1]), 32'h0);
    check("endrop_tick1", 32'(output_tick[1]), 32'h0);
    input_en[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("reen_tick1", 32'(output_tick[1]), 32'(i == 5));
      check("reen_clk1", 32'(output_clk[1]), 32'(i == 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
